imem_load_arbiter: RTL and testbench
====================================

Name: imem_load_arbiter

Overview:
Owns the single port of the 1024x32 instruction memory and switches it between a boot/reload word stream and the core fetch path. After reset, words streamed over a valid/ready interface are written to consecutive word addresses while the core is held in reset. On the last word the block hands the port to the core fetch path and releases the core. It sits between the boot source (UART/debug loader), the instruction memory array and the single-cycle core.

Parameters:
DEPTH, 1024, number of 32-bit words in the instruction memory
ADDR_W, 10, word-address width (log2 DEPTH)
LOAD_BASE, 0, first word address written by a load

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
ld_valid  input  1  loader word valid
ld_data  input  32  loader instruction word
ld_last  input  1  qualifies final word of the image (sampled with ld_valid)
ld_ready  output  1  block can accept a loader word this cycle
reload_req  input  1  single-cycle pulse requesting a new image load
fetch_addr  input  32  core PC (byte address)
fetch_data  output  32  instruction to core
core_rst  output  1  active-high reset to core; high whenever core must not fetch
mem_we  output  1  memory write enable (write on clk rising edge)
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data (asynchronous read)
load_count  output  ADDR_W+1  words accepted in current/last load
load_err  output  1  sticky: image exceeded DEPTH-LOAD_BASE words or misaligned fetch seen

Behaviour:
- States: LOAD, DONE, RUN. rst asserted (async) -> LOAD, load_count=0, load_err=0, core_rst=1, ld_ready=1, mem_we=0, fetch_data=0.
- LOAD: ld_ready=1. Beat accepted when ld_valid&ld_ready. On accept: mem_we=1 (combinational), mem_addr=LOAD_BASE+load_count, mem_wdata=ld_data; load_count increments at clk edge. No beat: mem_we=0, mem_addr=LOAD_BASE+load_count.
- LOAD exit: accepted beat with ld_last=1 -> DONE. Accepted beat without ld_last when it fills address DEPTH-1 -> DONE, load_err set 1. Words beyond DEPTH are never written.
- DONE: exactly one cycle; ld_ready=0, mem_we=0, core_rst=1. Next state is always RUN.
- RUN: core_rst=0, ld_ready=0, mem_we=0, mem_addr=fetch_addr[ADDR_W+1:2], fetch_data=mem_rdata (combinational, zero added latency). fetch_addr[1:0]!=0 -> fetch_data=32'h00000013 (NOP), load_err set 1.
- Outside RUN: fetch_data=32'h0.
- Latency: last beat accepted in cycle N -> DONE in N+1 -> RUN in N+2; core_rst falls at N+2.
- reload_req in RUN -> LOAD next cycle; load_count cleared to 0, load_err cleared, core_rst=1 same edge. reload_req in LOAD or DONE is ignored.
- ld_valid in DONE/RUN is ignored (not accepted, not written).
- load_count is held after load completes; readable in RUN.
- rst asserted mid-load: immediate return to LOAD with count 0. Partially written words remain in memory and are overwritten by the next load.
- All state changes occur on clk rising edge except async reset entry.

Test Plan:
- Reset then stream 3 words 0xFFC4A303, 0x0064A423, 0x00000013 (last on 3rd), ld_valid held high -> mem_we high 3 cycles at addr 0,1,2; DONE next; core_rst falls 2 cycles after 3rd beat; load_count=3.
- RUN, fetch_addr=0x4 with mem_rdata=0x0064A423 -> fetch_data=0x0064A423 same cycle; mem_we=0.
- Loader with ld_valid toggling every other cycle, 4 words -> exactly 4 writes at addr 0..3, no write on idle cycles, load_count=4.
- Stream 1025 words without ld_last -> writes addr 0..1023, DONE after 1024th beat, load_err=1, 1025th beat not accepted (ld_ready=0).
- In RUN pulse reload_req, load 1 word 0xDEADBEEF last -> core_rst high next cycle, addr 0 written, load_err=0, RUN resumes 2 cycles after beat.
- Assert rst after 2 of 5 beats -> immediate LOAD, load_count=0, core_rst=1; fetch_addr=0x2 in RUN -> fetch_data=0x00000013, load_err=1.

Source files
------------

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: hands the single instruction-memory port to a boot/reload word stream, then to the core fetch path.
module imem_load_arbiter #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload_req,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              core_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {LOAD, DONE, RUN} state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] wr_addr;
    logic            accept, full, misaligned, unused_fetch;

    assign wr_addr      = (ADDR_W+1)'(LOAD_BASE) + load_count;
    assign full         = wr_addr == (ADDR_W+1)'(DEPTH-1);
    assign misaligned   = fetch_addr[1:0] != 2'b00;
    assign unused_fetch = ^{fetch_addr[31:ADDR_W+2]};
    assign mem_wdata    = ld_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= LOAD;
        else     state <= state_nxt;

    // A reload wipes the count and the sticky error together with leaving RUN.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else if (state == RUN && reload_req) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else begin
            if (accept) load_count <= load_count + 1'b1;
            if ((accept && full && !ld_last) || (state == RUN && misaligned)) load_err <= 1'b1;
        end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        ld_ready   = 1'b0;
        core_rst   = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = wr_addr[ADDR_W-1:0];
        fetch_data = '0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                accept   = ld_valid;
                mem_we   = ld_valid;
                if (ld_valid && (ld_last || full)) state_nxt = DONE;
            end
            DONE: state_nxt = RUN;
            RUN: begin
                core_rst   = 1'b0;
                mem_addr   = fetch_addr[ADDR_W+1:2];
                fetch_data = misaligned ? NOP : mem_rdata;
                if (reload_req) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: directed checks of load, run, overflow, reload and reset behaviour against a behavioural memory.
module tb_imem_load_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ld_valid = 1'b0, ld_last = 1'b0, reload_req = 1'b0;
    logic [31:0] ld_data = '0, fetch_addr = '0;
    logic        ld_ready, core_rst, mem_we, load_err;
    logic [31:0] fetch_data, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic [10:0] load_count;
    logic [31:0] mem [1024];
    int          vectors = 0, fails = 0;

    imem_load_arbiter dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .reload_req(reload_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .core_rst(core_rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .load_count(load_count), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input logic [31:0] a);
        ld_valid = 1'b1; ld_data = d; ld_last = l;
        #1;
        chk("beat_we", mem_we, 1);
        chk("beat_addr", mem_addr, a);
        chk("beat_wdata", mem_wdata, d);
        step;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        logic [31:0] img [3];
        img = '{32'hFFC4A303, 32'h0064A423, 32'h00000013};
        #2;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_load_err", load_err, 0);
        step;
        rst = 1'b0;

        // 3-word image, valid held high through DONE
        for (int i = 0; i < 3; i++) beat(img[i], i == 2, i);
        ld_valid = 1'b1;
        #1;
        chk("done_ld_ready", ld_ready, 0);
        chk("done_mem_we", mem_we, 0);
        chk("done_core_rst", core_rst, 1);
        chk("done_count", load_count, 3);
        step;
        ld_valid = 1'b0; fetch_addr = 32'h4;
        #1;
        chk("run_core_rst", core_rst, 0);
        chk("run_fetch4", fetch_data, 32'h0064A423);
        chk("run_mem_we", mem_we, 0);
        fetch_addr = 32'h0;
        #1;
        chk("run_fetch0", fetch_data, 32'hFFC4A303);
        chk("run_err", load_err, 0);

        // reload, then 4 words with valid toggling
        reload_req = 1'b1;
        step;
        reload_req = 1'b0;
        chk("rl1_core_rst", core_rst, 1);
        chk("rl1_count", load_count, 0);
        for (int i = 0; i < 4; i++) begin
            beat(32'hA0 + i, i == 3, i);
            if (i != 3) begin
                #1;
                chk("idle_we", mem_we, 0);
                chk("idle_addr", mem_addr, i + 1);
                step;
            end
        end
        chk("tog_done_count", load_count, 4);
        step;
        fetch_addr = 32'hC;
        #1;
        chk("tog_run_core_rst", core_rst, 0);
        chk("tog_fetch", fetch_data, 32'hA3);

        // overflow: 1025 words without last
        reload_req = 1'b1;
        step;
        reload_req = 1'b0;
        for (int i = 0; i < 1024; i++) beat(32'h1000 + i, 1'b0, i);
        ld_valid = 1'b1; ld_data = 32'hBAD0BAD0;
        #1;
        chk("ovf_ld_ready", ld_ready, 0);
        chk("ovf_mem_we", mem_we, 0);
        chk("ovf_err", load_err, 1);
        chk("ovf_count", load_count, 1024);
        step;
        fetch_addr = 32'hFFC;
        #1;
        chk("ovf_run_core_rst", core_rst, 0);
        chk("ovf_fetch_last", fetch_data, 32'h13FF);
        chk("ovf_run_we", mem_we, 0);
        ld_valid = 1'b0;

        // reload with a single word
        reload_req = 1'b1;
        step;
        reload_req = 1'b0;
        chk("rl2_core_rst", core_rst, 1);
        chk("rl2_err_clear", load_err, 0);
        beat(32'hDEADBEEF, 1'b1, 0);
        chk("rl2_done_core_rst", core_rst, 1);
        step;
        fetch_addr = 32'h0;
        #1;
        chk("rl2_run_core_rst", core_rst, 0);
        chk("rl2_fetch", fetch_data, 32'hDEADBEEF);
        chk("rl2_count", load_count, 1);

        // reset mid-load, reload_req ignored in LOAD
        reload_req = 1'b1;
        step;
        reload_req = 1'b0;
        beat(32'h11, 1'b0, 0);
        beat(32'h22, 1'b0, 1);
        reload_req = 1'b1;
        step;
        reload_req = 1'b0;
        chk("ld_reload_ignored", load_count, 2);
        chk("ld_reload_core_rst", core_rst, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", load_count, 0);
        chk("mid_rst_core_rst", core_rst, 1);
        chk("mid_rst_ld_ready", ld_ready, 1);
        step;
        rst = 1'b0;
        beat(32'h33, 1'b1, 0);
        step;
        fetch_addr = 32'h2;
        #1;
        chk("mis_fetch_nop", fetch_data, 32'h00000013);
        chk("mis_err_pre", load_err, 0);
        step;
        chk("mis_err", load_err, 1);
        fetch_addr = 32'h0;
        #1;
        chk("mis_err_sticky", load_err, 1);
        chk("mis_fetch_ok", fetch_data, 32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
